// File: rtl/pipe_stage_skid_pkg.sv
// pipe_pkg: shared state encoding and EX->WB payload bundle for pipeline stages
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} pipe_state_e;
  typedef struct packed {
    logic [2:0]  load_type;
    logic [1:0]  store_type;
    logic        we;
    logic        branch_ctrl;
    logic [31:0] ex_data;
    logic [31:0] store_data;
    logic        comp_flag;
  } ex_wb_payload_t;
  localparam int EX_WB_W = $bits(ex_wb_payload_t);
endpackage

// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if: valid/ready handshake bundle plus flush for one pipeline boundary
interface pipe_stage_skid_if import pipe_pkg::*; #(
  parameter int DATA_W = EX_WB_W
);
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  modport master (output flush_i, in_valid_i, in_data_i, out_ready_i,
                  input  in_ready_o, out_valid_o, out_data_o);
  modport slave  (input  flush_i, in_valid_i, in_data_i, out_ready_i,
                  output in_ready_o, out_valid_o, out_data_o);
endinterface

// File: rtl/pipe_stage_skid_stall_counter.sv
// pipe_stall_counter: saturating back-pressure cycle counter, used with PIPE_STAGE_PERF_EN
module pipe_stall_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage with 2-entry skid buffer, registered ready and flush.
// Optional stall counter port stall_cnt_o enabled by PIPE_STAGE_PERF_EN.
module pipe_stage_skid import pipe_pkg::*; #(
  parameter int DATA_W = EX_WB_W
`ifdef PIPE_STAGE_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_stage_skid_if.slave bus,
  output logic [1:0]       occupancy_o
`ifdef PIPE_STAGE_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt_o
`endif
);
  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
  logic              in_xfer, out_xfer;
  always_comb begin
    in_xfer  = bus.in_valid_i & bus.in_ready_o;
    out_xfer = bus.out_valid_o & bus.out_ready_i;
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    if (bus.flush_i) state_d = EMPTY;
    else
      case (state_q)
        EMPTY: if (in_xfer) begin
          state_d = BUSY;
          main_d  = bus.in_data_i;
        end
        BUSY: if (in_xfer && out_xfer) main_d = bus.in_data_i;
          else if (in_xfer) begin
            state_d = FULL;
            skid_d  = bus.in_data_i;
          end
          else if (out_xfer) state_d = EMPTY;
        FULL: if (out_xfer) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  assign bus.in_ready_o  = state_q != FULL;
  assign bus.out_valid_o = state_q != EMPTY;
  assign bus.out_data_o  = main_q;
  assign occupancy_o     = state_q == FULL ? 2'd2 : state_q == BUSY ? 2'd1 : 2'd0;
`ifdef PIPE_STAGE_PERF_EN
  pipe_stall_counter #(.CNT_W(CNT_W)) u_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (bus.out_valid_o & ~bus.out_ready_i),
    .cnt_o (stall_cnt_o)
  );
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed and random checks of pipe_stage_skid against a queue model
module tb_pipe_stage_skid;
  import pipe_pkg::*;
  localparam int W = EX_WB_W;
  localparam int CW = 4;
  logic clk = 0;
  logic rst_n = 0;
  logic [1:0] occupancy;
  int total = 0;
  int bad = 0;
  logic [W-1:0] mq[$];
  int scnt = 0;
  pipe_stage_skid_if bus ();
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] stall_cnt;
  pipe_stage_skid #(.CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .occupancy_o (occupancy),
    .stall_cnt_o (stall_cnt)
  );
`else
  pipe_stage_skid dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .occupancy_o (occupancy)
  );
`endif
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare();
    chk("in_ready", W'(bus.in_ready_o), W'(mq.size() < 2));
    chk("out_valid", W'(bus.out_valid_o), W'(mq.size() > 0));
    chk("occupancy", W'(occupancy), W'(mq.size()));
    if (mq.size() > 0) chk("out_data", bus.out_data_o, mq[0]);
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_cnt", W'(stall_cnt), W'(scnt));
`endif
  endtask

  // One clock: apply inputs, advance the queue model with the pre-edge view, then check.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    bit ov, ir;
    bus.in_valid_i  = v;
    bus.in_data_i   = d;
    bus.out_ready_i = r;
    bus.flush_i     = f;
    @(posedge clk);
    ov = mq.size() > 0;
    ir = mq.size() < 2;
    if (ov && !r && scnt < (1 << CW) - 1) scnt++;
    if (f) mq.delete();
    else begin
      if (ov && r) void'(mq.pop_front());
      if (v && ir) mq.push_back(d);
    end
    #1 compare();
  endtask

  initial begin
    bus.in_valid_i = 0;
    bus.in_data_i = '0;
    bus.out_ready_i = 0;
    bus.flush_i = 0;
    #12;
    chk("rst_valid", W'(bus.out_valid_o), '0);
    chk("rst_ready", W'(bus.in_ready_o), W'(1));
    chk("rst_data", bus.out_data_o, '0);
    chk("rst_occ", W'(occupancy), '0);
    rst_n = 1;
    // streaming 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      step(1, W'(i), 1, 0);
      chk("stream_data", bus.out_data_o, W'(i));
      chk("stream_occ", W'(occupancy), W'(1));
    end
    step(0, '0, 1, 0);
    // back-pressure
    step(1, W'('hA1), 0, 0);
    step(1, W'('hA2), 0, 0);
    chk("bp_occ", W'(occupancy), W'(2));
    chk("bp_ready", W'(bus.in_ready_o), '0);
    step(1, W'('hA3), 0, 0);
    chk("bp_hold", bus.out_data_o, W'('hA1));
    step(0, '0, 1, 0);
    chk("bp_second", bus.out_data_o, W'('hA2));
    step(1, W'('hA3), 1, 0);
    chk("bp_third", bus.out_data_o, W'('hA3));
    step(0, '0, 1, 0);
    // flush while FULL
    step(1, W'('h11), 0, 0);
    step(1, W'('h22), 0, 0);
    step(1, W'('hFF), 0, 1);
    chk("flush_valid", W'(bus.out_valid_o), '0);
    chk("flush_ready", W'(bus.in_ready_o), W'(1));
    chk("flush_occ", W'(occupancy), '0);
    step(0, '0, 1, 0);
    chk("flush_no_ff", W'(bus.out_valid_o), '0);
    // async reset between edges while BUSY
    step(1, W'('h55), 1, 0);
    #3 rst_n = 0;
    #1;
    chk("arst_valid", W'(bus.out_valid_o), '0);
    chk("arst_data", bus.out_data_o, '0);
    chk("arst_ready", W'(bus.in_ready_o), W'(1));
    chk("arst_occ", W'(occupancy), '0);
    mq.delete();
    scnt = 0;
    #1 rst_n = 1;
    // long stall then flush
    step(1, W'('h77), 0, 0);
    for (int i = 0; i < 20; i++) step(0, '0, 0, 0);
`ifdef PIPE_STAGE_PERF_EN
    chk("perf_sat", W'(stall_cnt), W'(4'hF));
`endif
    step(0, '0, 0, 1);
`ifdef PIPE_STAGE_PERF_EN
    chk("perf_flush_keep", W'(stall_cnt), W'(4'hF));
`endif
    // random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), {$urandom(), $urandom(), $urandom()},
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic, parametrised pipeline register stage for inter-stage boundaries (EX->WB, ID->EX, ...).
- Replaces per-boundary stall-mux flop blocks with one valid/ready stage.
- Carries an opaque payload with a 2-entry skid buffer, so in_ready_o is registered and ready never forms a combinational path across stages.
- Adds synchronous flush (bubble insertion on branch/exception) and full-throughput back-pressure.

Parameters:
- DATA_W, 72, payload width in bits. 72 = EX->WB bundle: load type 3, store type 2, write enable 1, branch ctrl 1, ex data 32, store data 32, comp flag 1.
- CNT_W, 32, width of the performance counter. Used only with PIPE_STAGE_PERF_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous kill of all held and incoming entries.
- in_valid_i  in  1  upstream payload valid.
- in_ready_o  out  1  stage can accept; registered.
- in_data_i  in  DATA_W  upstream payload.
- out_valid_o  out  1  downstream payload valid.
- out_ready_i  in  1  downstream accepts.
- out_data_o  out  DATA_W  downstream payload.
- occupancy_o  out  2  entries held: 0, 1 or 2.
- stall_cnt_o  out  CNT_W  back-pressure cycle count; present only with PIPE_STAGE_PERF_EN.

Behaviour:
- Reset (rst_n low, async): state EMPTY, out_valid_o=0, out_data_o=0, skid register=0, in_ready_o=1, occupancy_o=0, stall_cnt_o=0.
- Handshakes:
  - Input transfer: in_valid_i & in_ready_o at a rising edge.
  - Output transfer: out_valid_o & out_ready_i at a rising edge.
  - in_data_i is ignored when in_ready_o=0.
- Output stability: while out_valid_o=1 and out_ready_i=0, out_valid_o and out_data_o hold stable.
- Latency and throughput: 1 cycle from input transfer to out_valid_o in EMPTY; sustained 1 transfer/cycle when out_ready_i=1.
- States (main = output register; skid = second register):
  - EMPTY: in transfer -> BUSY, main<=in_data_i. Otherwise stay.
  - BUSY:
    - in transfer & out transfer -> BUSY, main<=in_data_i.
    - in transfer & no out transfer -> FULL, skid<=in_data_i.
    - no in & out transfer -> EMPTY.
    - Otherwise stay.
  - FULL (in_ready_o=0): out transfer -> BUSY, main<=skid. Otherwise stay.
- Outputs derived from state only, all registered:
  - in_ready_o = (state != FULL).
  - out_valid_o = (state != EMPTY).
  - occupancy_o = 0 / 1 / 2 for EMPTY / BUSY / FULL.
- Flush:
  - flush_i=1 at an edge forces EMPTY, overriding all transitions.
  - An input offered in the same cycle is discarded.
  - An output transfer in the flush cycle still counts as taken downstream.
  - Data registers are not cleared; only valid drops.
  - Next cycle: out_valid_o=0, in_ready_o=1.
- Simultaneous flush & in transfer: entry is lost, and upstream treats it as accepted.
- Reset mid-operation: immediate return to reset values; no partial state is retained.
- Data registers load only on the listed transitions, so there is no toggle when idle.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - Port stall_cnt_o exists.
  - Increments each cycle with out_valid_o=1 & out_ready_i=0.
  - Saturates at all-ones, with no wrap.
  - Cleared only by reset; flush does not clear it.
- Undefined: port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Package pipe_pkg:
  - typedef enum logic [1:0] pipe_state_e {EMPTY, BUSY, FULL}.
  - typedef struct packed ex_wb_payload_t: the 72-bit bundle.
  - localparam EX_WB_W = $bits(ex_wb_payload_t).
- Boundary wrappers pack and unpack the struct into in_data_i / out_data_o.
- Sub-module: pipe_stall_counter (saturating CNT_W counter), instantiated only under PIPE_STAGE_PERF_EN.
- Everything else stays in one module.

Test Plan:
- Streaming: reset, then in_valid_i=1 for 8 cycles with data 0x01..0x08 and out_ready_i=1 -> out_data_o 0x01..0x08 on consecutive cycles, first one cycle after first accept; occupancy_o stays 1; in_ready_o stays 1.
- Back-pressure: out_ready_i=0 while sending 0xA1, 0xA2 -> occupancy_o=2, in_ready_o=0, out_data_o holds 0xA1. Offered 0xA3 is ignored. Raise out_ready_i -> 0xA1, 0xA2, then 0xA3 after re-offer, in order with none lost.
- Flush in FULL: state FULL, assert flush_i one cycle with in_valid_i=1 (0xFF) -> next cycle out_valid_o=0, occupancy_o=0, in_ready_o=1; 0xFF never appears.
- Async reset mid-stream: rst_n low between clock edges while in BUSY -> out_valid_o=0, out_data_o=0, in_ready_o=1 immediately, before the next edge.
- Perf (PIPE_STAGE_PERF_EN, CNT_W=4): hold out_valid_o=1, out_ready_i=0 for 20 cycles -> stall_cnt_o saturates at 0xF; a subsequent flush leaves it at 0xF.
